fb_arbiter: RTL

- Owns the single-port 12-bit BGR pixel RAM (640x480 used, address {Y[8:0],X[9:0]}).
- Shares the RAM between three requesters:
  - display scan-out from the VGA timing generator (absolute priority);
  - two game-side pixel writers, e.g. bird/pipe renderer and score overlay (round-robin);
  - an internal clear engine that fills the frame with a colour.
- Sits between the game logic, the VGA controller and the frame-buffer RAM.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_rr_arb.sv | 31 +++
 rtl/fb_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants: geometry, clear-FSM encoding, pixel type.
package fb_pkg;

  localparam int FB_XW    = 10;
  localparam int FB_YW    = 9;
  localparam int FB_AW    = FB_XW + FB_YW;
  localparam int FB_X_MAX = 640;
  localparam int FB_Y_MAX = 480;

  typedef logic [11:0] bgr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_st_e;

  // RAM address is row-major {y,x}
  function automatic logic [FB_AW-1:0] fb_addr(input logic [FB_YW-1:0] y,
                                               input logic [FB_XW-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the favoured writer and only
// moves on a completed transfer.
module fb_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] ready_o,
  output logic       gnt_o,
  output logic       xfer_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    case (valid_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      default: gnt_o = ptr_q;
    endcase
    ready_o = en_i ? (gnt_o ? 2'b10 : 2'b01) : 2'b00;
    xfer_o  = |(ready_o & valid_i);
    ptr_d   = xfer_o ? ~gnt_o : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM port arbiter: display reads, clear engine, two RR pixel writers.
// Optional FB_STALL_CNT_EN adds a saturating writer-stall counter on stall_cnt.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int XW    = FB_XW,
  parameter int YW    = FB_YW,
  parameter int X_MAX = FB_X_MAX,
  parameter int Y_MAX = FB_Y_MAX
) (
  input  logic          vga_clk,
  input  logic          clrn,
  input  logic          disp_rd,
  input  logic [XW-1:0] disp_x,
  input  logic [YW-1:0] disp_y,
  output bgr_t          disp_data,
  input  logic          wr0_valid,
  output logic          wr0_ready,
  input  logic [XW-1:0] wr0_x,
  input  logic [YW-1:0] wr0_y,
  input  bgr_t          wr0_bgr,
  input  logic          wr1_valid,
  output logic          wr1_ready,
  input  logic [XW-1:0] wr1_x,
  input  logic [YW-1:0] wr1_y,
  input  bgr_t          wr1_bgr,
  input  logic          clear_req,
  input  bgr_t          clear_bgr,
  output logic          clear_busy,
  output logic          clear_done,
  output logic [XW+YW-1:0] mem_addr,
  output logic          mem_we,
  output bgr_t          mem_wdata,
  input  bgr_t          mem_rdata
`ifdef FB_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int AW = XW + YW;
  localparam logic [XW-1:0] XLAST = XW'(X_MAX - 1);
  localparam logic [YW-1:0] YLAST = YW'(Y_MAX - 1);

  clr_st_e       st_q, st_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  bgr_t          color_q, color_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  bgr_t          wdata_q, wdata_d;

  logic [1:0]    wr_ready;
  logic          gnt, wr_xfer;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  bgr_t          wbgr;
  logic          w_in_range;

  assign clear_busy = (st_q == ST_CLEAR);
  assign clear_done = (st_q == ST_DONE);
  assign disp_data  = mem_rdata;
  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign wr0_ready  = wr_ready[0];
  assign wr1_ready  = wr_ready[1];

  fb_rr_arb u_arb (
    .clk     (vga_clk),
    .rst     (clrn),
    .en_i    (~disp_rd & ~clear_busy),
    .valid_i ({wr1_valid, wr0_valid}),
    .ready_o (wr_ready),
    .gnt_o   (gnt),
    .xfer_o  (wr_xfer)
  );

  assign wx         = gnt ? wr1_x   : wr0_x;
  assign wy         = gnt ? wr1_y   : wr0_y;
  assign wbgr       = gnt ? wr1_bgr : wr0_bgr;
  // Out-of-range pixels are still handshaken so a renderer never stalls on them
  assign w_in_range = (wx <= XLAST) && (wy <= YLAST);

  always_comb begin
    st_d    = st_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;

    // RAM slot: display > clear > writer
    if (disp_rd) begin
      addr_d = {disp_y, disp_x};
    end else if (st_q == ST_CLEAR) begin
      addr_d  = {cy_q, cx_q};
      we_d    = 1'b1;
      wdata_d = color_q;
    end else if (wr_xfer && w_in_range) begin
      addr_d  = {wy, wx};
      we_d    = 1'b1;
      wdata_d = wbgr;
    end

    case (st_q)
      ST_IDLE: begin
        if (clear_req) begin
          st_d    = ST_CLEAR;
          color_d = clear_bgr;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      ST_CLEAR: begin
        if (!disp_rd) begin
          if (cx_q == XLAST) begin
            cx_d = '0;
            if (cy_q == YLAST) st_d = ST_DONE;
            else               cy_d = cy_q + YW'(1);
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
      ST_DONE:  st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or posedge clrn) begin
    if (clrn) begin
      st_q    <= ST_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      color_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      st_q    <= st_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall;

  assign stall     = (wr0_valid | wr1_valid) & ~(wr0_ready | wr1_ready);
  assign stall_cnt = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (clear_done)                      stall_d = '0;
    else if (stall && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge vga_clk or posedge clrn) begin
    if (clrn) stall_q <= '0;
    else      stall_q <= stall_d;
  end
`endif

endmodule
